adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pipe.sv | 144 ++++++++++++++
 tb/tb_adder_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// adder_pipe: multi-mode adder with an elastic valid/ready pipeline.
//
// Purpose:
//   Accepts operand beats (in1, in2, mode) and produces one result per beat
//   STAGES cycles later when the consumer is not stalling. Modes:
//     00 wrap add        flag = unsigned carry-out
//     01 wrap sub        flag = unsigned borrow (in1 < in2)
//     10 unsigned sat add (clamp to all-ones), flag = carry-out
//     11 signed sat add   (clamp to max/min signed), flag = signed overflow
//   A saturating counter tallies transferred results whose flag is set.
//
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   in_valid/in_ready   operand handshake; in1, in2, mode sampled on accept
//   out_valid/out_ready result handshake; out, out_ovf held while stalled
//   ovf_cnt, clr_cnt    saturating overflow count and its synchronous clear
//   busy                any pipeline stage holds a beat
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             clr_cnt,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             signed_ovf;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] ovf_q;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [STAGES-1:0] adv;
  logic              transfer;

  // Result is computed before the first register so every stage just moves data.
  always_comb begin
    sum_ext    = {1'b0, in1} + {1'b0, in2};
    diff_ext   = {1'b0, in1} - {1'b0, in2};
    // Signed overflow: operands agree in sign but the sum does not.
    signed_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_ext[WIDTH-1] != in1[WIDTH-1]);
    res_c      = sum_ext[WIDTH-1:0];
    ovf_c      = sum_ext[WIDTH];
    case (mode)
      2'b00: begin
        res_c = sum_ext[WIDTH-1:0];
        ovf_c = sum_ext[WIDTH];
      end
      2'b01: begin
        // The extra bit of the widened difference is the unsigned borrow.
        res_c = diff_ext[WIDTH-1:0];
        ovf_c = diff_ext[WIDTH];
      end
      2'b10: begin
        res_c = sum_ext[WIDTH] ? ALL_ONES : sum_ext[WIDTH-1:0];
        ovf_c = sum_ext[WIDTH];
      end
      default: begin
        res_c = signed_ovf ? (in1[WIDTH-1] ? MIN_NEG : MAX_POS) : sum_ext[WIDTH-1:0];
        ovf_c = signed_ovf;
      end
    endcase
  end

  // A stage may advance if it or any stage downstream of it is empty, or if
  // the consumer is taking the last beat. This collapses bubbles and is the
  // flattened form of "next stage empty or advancing".
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!valid_q[j]) adv[k] = 1'b1;
      end
    end
  end

  // Data registers only load when a real beat arrives, so a stalled or empty
  // stage keeps its last contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ovf_q   <= '0;
      for (int k = 0; k < STAGES; k++) res_q[k] <= '0;
    end else begin
      if (adv[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          res_q[0] <= res_c;
          ovf_q[0] <= ovf_c;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            res_q[k] <= res_q[k-1];
            ovf_q[k] <= ovf_q[k-1];
          end
        end
      end
    end
  end

  // Clear has priority over a same-cycle overflow transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (clr_cnt) begin
      ovf_cnt <= '0;
    end else if (transfer && out_ovf && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

  // in_ready is forced low while reset is asserted.
  assign in_ready  = rst_n & adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign out       = res_q[STAGES-1];
  assign out_ovf   = ovf_q[STAGES-1];
  assign transfer  = out_valid & out_ready;
  assign busy      = |valid_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed testbench for adder_pipe (WIDTH=32, STAGES=2, CNT_W=2).
module tb_adder_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        out_ovf;
  logic [1:0]  ovf_cnt;
  logic        clr_cnt;
  logic        busy;

  int checks;
  int errors;
  int sent;
  int recv;
  logic acc;

  adder_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_ovf   (out_ovf),
    .ovf_cnt   (ovf_cnt),
    .clr_cnt   (clr_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] m);
    in_valid = v;
    in1      = a;
    in2      = b;
    mode     = m;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One beat through an idle pipe with out_ready high: accept, check latency,
  // check result, then check the counter after the transfer.
  task automatic sendAndCheck(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] m, input logic [31:0] exp_out,
                              input logic exp_ovf, input logic [1:0] exp_cnt,
                              input logic do_clr);
    @(negedge clk);
    applyStimulus(1'b1, a, b, m);
    #1;
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 32'd0, 2'b00);
    #1;
    checkOutput({tag, " early out_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    clr_cnt = do_clr;
    #1;
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, " out"}, out, exp_out);
    checkOutput({tag, " out_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    @(negedge clk);
    clr_cnt = 1'b0;
    #1;
    checkOutput({tag, " ovf_cnt"}, 32'(ovf_cnt), 32'(exp_cnt));
    checkOutput({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 2'b00);

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst out", out, 32'd0);
    checkOutput("rst out_ovf", 32'(out_ovf), 32'd0);
    checkOutput("rst ovf_cnt", 32'(ovf_cnt), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post-rst in_ready", 32'(in_ready), 32'd1);

    // Arithmetic vectors; ovf_cnt (2 bits) saturates at 3
    sendAndCheck("add 5+3",      32'h5,        32'h3,        2'b00, 32'h8,        1'b0, 2'd0, 1'b0);
    sendAndCheck("add wrap",     32'hFFFFFFFF, 32'h1,        2'b00, 32'h0,        1'b1, 2'd1, 1'b0);
    sendAndCheck("usat add",     32'hFFFFFFFF, 32'h1,        2'b10, 32'hFFFFFFFF, 1'b1, 2'd2, 1'b0);
    sendAndCheck("sub borrow",   32'h3,        32'h5,        2'b01, 32'hFFFFFFFE, 1'b1, 2'd3, 1'b0);
    sendAndCheck("ssat pos",     32'h7FFFFFFF, 32'h1,        2'b11, 32'h7FFFFFFF, 1'b1, 2'd3, 1'b0);
    sendAndCheck("ssat neg",     32'h80000000, 32'hFFFFFFFF, 2'b11, 32'h80000000, 1'b1, 2'd3, 1'b0);
    sendAndCheck("ssat no ovf",  32'hFFFFFFFF, 32'h1,        2'b11, 32'h0,        1'b0, 2'd3, 1'b0);
    sendAndCheck("sub 5-3",      32'h5,        32'h3,        2'b01, 32'h2,        1'b0, 2'd3, 1'b0);
    sendAndCheck("usat 1+2",     32'h1,        32'h2,        2'b10, 32'h3,        1'b0, 2'd3, 1'b0);

    // Stream 6 beats with out_ready low for 5 cycles
    out_ready = 1'b0;
    sent = 0;
    recv = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      applyStimulus(sent < 6, 32'(10 * sent), 32'd1, 2'b00);
      #1;
      acc = in_ready;
      checkOutput($sformatf("stall in_ready c%0d", c), 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
      if (c >= 2) begin
        checkOutput($sformatf("stall out_valid c%0d", c), 32'(out_valid), 32'd1);
        checkOutput($sformatf("stall out c%0d", c), out, 32'd1);
        checkOutput($sformatf("stall out_ovf c%0d", c), 32'(out_ovf), 32'd0);
      end
      @(posedge clk);
      if (acc) sent++;
    end
    checkOutput("accepted before stall", 32'(sent), 32'd2);

    // Release: results drain back-to-back while remaining beats are accepted
    for (int c = 0; c < 8 && recv < 6; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      applyStimulus(sent < 6, 32'(10 * sent), 32'd1, 2'b00);
      #1;
      acc = in_ready;
      if (sent < 6) checkOutput($sformatf("b2b in_ready %0d", sent), 32'(in_ready), 32'd1);
      checkOutput($sformatf("b2b out_valid %0d", recv), 32'(out_valid), 32'd1);
      checkOutput($sformatf("b2b out %0d", recv), out, 32'(10 * recv + 1));
      @(posedge clk);
      if (acc && sent < 6) sent++;
      recv++;
    end
    checkOutput("stream all accepted", 32'(sent), 32'd6);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 32'd0, 2'b00);
    #1;
    checkOutput("stream drained out_valid", 32'(out_valid), 32'd0);
    checkOutput("stream drained busy", 32'(busy), 32'd0);

    // Reset with two overflowing beats in flight
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      applyStimulus(1'b1, 32'hFFFFFFFF, 32'h2, 2'b00);
      #1;
      checkOutput($sformatf("inflight in_ready %0d", c), 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 32'd0, 2'b00);
    #1;
    checkOutput("inflight busy", 32'(busy), 32'd1);
    checkOutput("inflight out_valid", 32'(out_valid), 32'd1);
    checkOutput("ovf_cnt saturated", 32'(ovf_cnt), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst ovf_cnt", 32'(ovf_cnt), 32'd0);
    checkOutput("midrst in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst out", out, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("after rst out_valid c%0d", c), 32'(out_valid), 32'd0);
      checkOutput($sformatf("after rst busy c%0d", c), 32'(busy), 32'd0);
    end

    // Counter saturation at CNT_W=2 and clear priority
    sendAndCheck("cnt 1", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'hFFFFFFFE, 1'b1, 2'd1, 1'b0);
    sendAndCheck("cnt 2", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'hFFFFFFFE, 1'b1, 2'd2, 1'b0);
    sendAndCheck("cnt 3", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'hFFFFFFFE, 1'b1, 2'd3, 1'b0);
    sendAndCheck("cnt sat", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'hFFFFFFFE, 1'b1, 2'd3, 1'b0);
    sendAndCheck("cnt clr", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'hFFFFFFFE, 1'b1, 2'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
